// File: rtl/pipe_pkg.sv
// Shared constants and hazard-field types for the pipeline stage registers.
package pipe_pkg;

  localparam int              REG_ADDR_W = 5;
  localparam logic [4:0]      REG_ZERO   = 5'd0;
  localparam int              TNEW_MAX   = 5;
  localparam int              TNEW_HZ_W  = $clog2(TNEW_MAX + 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] a3;
    logic                  grf_en;
    logic [TNEW_HZ_W-1:0]  tnew;
  } stage_hz_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one pipeline stage register: control, inputs, stage contents, forwarding query.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 256,
  parameter int TNEW_W    = 3,
  parameter int CNT_W     = 16
) ();

  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic [PAYLOAD_W-1:0]  in_payload;
  logic [REG_ADDR_W-1:0] in_a3;
  logic                  in_grf_en;
  logic [TNEW_W-1:0]     in_tnew;

  logic                  out_valid;
  logic [PAYLOAD_W-1:0]  out_payload;
  logic [REG_ADDR_W-1:0] out_a3;
  logic                  out_grf_en;
  logic [TNEW_W-1:0]     out_tnew;

  logic [REG_ADDR_W-1:0] q_rs;
  logic [REG_ADDR_W-1:0] q_rt;
  logic                  rs_hit;
  logic                  rs_ready;
  logic                  rt_hit;
  logic                  rt_ready;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output stall, flush, in_valid, in_payload, in_a3, in_grf_en, in_tnew, q_rs, q_rt,
    input  out_valid, out_payload, out_a3, out_grf_en, out_tnew,
    input  rs_hit, rs_ready, rt_hit, rt_ready, bubble_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_payload, in_a3, in_grf_en, in_tnew, q_rs, q_rt,
    output out_valid, out_payload, out_a3, out_grf_en, out_tnew,
    output rs_hit, rs_ready, rt_hit, rt_ready, bubble_cnt
  );

endinterface

// File: rtl/pipe_fwd_match.sv
// Forwarding match of one query address against a stage's registered hazard fields.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int TNEW_W = 3
) (
  input  logic                  valid,
  input  logic [REG_ADDR_W-1:0] a3,
  input  logic                  grf_en,
  input  logic [TNEW_W-1:0]     tnew,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  hit,
  output logic                  ready
);

  // $zero is never a real producer, so it can never be forwarded.
  assign hit   = valid & grf_en & (a3 != REG_ZERO) & (a3 == q_addr);
  assign ready = hit & (tnew == '0);

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: opaque payload plus hazard fields, stall/flush, bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W       = 256,
  parameter int TNEW_W          = 3,
  parameter bit BUBBLE_ON_STALL = 1'b0,
  parameter int CNT_W           = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  logic                  valid_q;
  logic [PAYLOAD_W-1:0]  payload_q;
  logic [REG_ADDR_W-1:0] a3_q;
  logic                  grf_en_q;
  logic [TNEW_W-1:0]     tnew_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  load_bubble;
  logic                  load_instr;
  logic [TNEW_W-1:0]     tnew_next;

  // An invalid input on a normal load is treated exactly like any other bubble.
  assign load_bubble = bus.flush
                     | (bus.stall & BUBBLE_ON_STALL)
                     | (~bus.stall & ~bus.in_valid);
  assign load_instr  = ~bus.flush & ~bus.stall & bus.in_valid;
  assign tnew_next   = (bus.in_tnew != '0) ? bus.in_tnew - 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      a3_q      <= '0;
      grf_en_q  <= 1'b0;
      tnew_q    <= '0;
      cnt_q     <= '0;
    end else begin
      if (load_bubble) begin
        valid_q   <= 1'b0;
        payload_q <= '0;
        a3_q      <= '0;
        grf_en_q  <= 1'b0;
        tnew_q    <= '0;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end else if (load_instr) begin
        valid_q   <= 1'b1;
        payload_q <= bus.in_payload;
        a3_q      <= bus.in_a3;
        grf_en_q  <= bus.in_grf_en;
        tnew_q    <= tnew_next;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_payload = payload_q;
  assign bus.out_a3      = a3_q;
  assign bus.out_grf_en  = grf_en_q;
  assign bus.out_tnew    = tnew_q;
  assign bus.bubble_cnt  = cnt_q;

  pipe_fwd_match #(.TNEW_W(TNEW_W)) u_fwd_rs (
    .valid  (valid_q),
    .a3     (a3_q),
    .grf_en (grf_en_q),
    .tnew   (tnew_q),
    .q_addr (bus.q_rs),
    .hit    (bus.rs_hit),
    .ready  (bus.rs_ready)
  );

  pipe_fwd_match #(.TNEW_W(TNEW_W)) u_fwd_rt (
    .valid  (valid_q),
    .a3     (a3_q),
    .grf_en (grf_en_q),
    .tnew   (tnew_q),
    .q_addr (bus.q_rt),
    .hit    (bus.rt_hit),
    .ready  (bus.rt_ready)
  );

endmodule
